mod_pow2_mul_seq: RTL and testbench

//   Iterative modular multiply-by-power-of-two: oData = (iData * 2^iShift) mod iMod.

---
 rtl/mod_pow2_mul_seq_pkg.sv | 22 ++
 rtl/mod_pow2_mul_seq_if.sv | 30 +++
 rtl/mod_pow2_mul_seq_doubler.sv | 23 ++
 rtl/mod_pow2_mul_seq.sv | 127 ++++++++++++
 tb/tb_mod_pow2_mul_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_pow2_mul_seq_pkg.sv
// Shared types for the modular multiply-by-power-of-two block.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and a scalar modular-doubling helper that
// mirrors one datapath step for use outside the datapath.
package mod_pow2_mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One modular doubling on up-to-63-bit operands: (2*x) mod m, assuming x < m.
  function automatic logic [63:0] mod_dbl(input logic [63:0] x, input logic [63:0] m);
    logic [63:0] t;
    t = x << 1;
    return (t >= m) ? (t - m) : t;
  endfunction

endpackage

// File: rtl/mod_pow2_mul_seq_if.sv
// Request/response bundle for mod_pow2_mul_seq.
// Latency: n/a (wires only).
// Backpressure: request side iValid/oReady, result side oValid/iReady.
//
// master: requester (drives operands and result ready).
// slave : the multiplier (drives request ready and the result).
interface mod_pow2_mul_seq_if #(
  parameter int BITWIDTH = 32,
  parameter int SHIFTW   = 6
);
  logic                iValid;
  logic                oReady;
  logic [BITWIDTH-1:0] iData;
  logic [BITWIDTH-1:0] iMod;
  logic [SHIFTW-1:0]   iShift;
  logic                oValid;
  logic                iReady;
  logic [BITWIDTH-1:0] oData;
  logic                oErr;

  modport master (
    output iValid, iData, iMod, iShift, iReady,
    input  oReady, oValid, oData, oErr
  );

  modport slave (
    input  iValid, iData, iMod, iShift, iReady,
    output oReady, oValid, oData, oErr
  );
endinterface

// File: rtl/mod_pow2_mul_seq_doubler.sv
// One combinational modular doubling: y = (2*x) mod mod, for x < mod.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: x (operand), mod (modulus), y (result).
module mod_pow2_mul_seq_doubler #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] x,
  input  logic [BITWIDTH-1:0] mod,
  output logic [BITWIDTH-1:0] y
);
  // Doubling is done one bit wider so the carry out of x is kept; this makes
  // the reduction exact for moduli right up to 2^BITWIDTH-1.
  logic [BITWIDTH:0] t;
  logic [BITWIDTH:0] m_ext;

  assign t     = {x, 1'b0};
  assign m_ext = {1'b0, mod};
  // Since x < mod, t < 2*mod, so a single conditional subtract suffices and
  // the result always fits back into BITWIDTH bits.
  assign y     = BITWIDTH'((t >= m_ext) ? (t - m_ext) : t);
endmodule

// File: rtl/mod_pow2_mul_seq.sv
// Iterative modular multiply by 2^k: oData = (iData * 2^iShift) mod iMod.
// Latency: accept edge + ceil(k/UNROLL) RUN edges; k=0 or bad operands finish on the accept edge.
// Backpressure: oReady only in IDLE; result held in DONE until iReady; iEn=0 freezes everything.
//
// Ports: iClk, iRst (sync, active high), iEn (global enable), iClr (abort to IDLE),
//        bus (slave side of mod_pow2_mul_seq_if: request, operands, result, error).
module mod_pow2_mul_seq
  import mod_pow2_mul_seq_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int SHIFTW   = 6,
  parameter int UNROLL   = 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iClr,
  mod_pow2_mul_seq_if.slave    bus
);

  state_t              state_q, state_d;
  logic [SHIFTW-1:0]   cnt_q, cnt_d;
  logic [BITWIDTH-1:0] x_q, x_d;
  logic [BITWIDTH-1:0] mod_q, mod_d;
  logic [BITWIDTH-1:0] odata_q, odata_d;
  logic                err_q, err_d;
  logic [BITWIDTH-1:0] run_res;
  logic [SHIFTW-1:0]   cnt_step;

  // UNROLL doublers in series. Stage i only applies its doubling while
  // i < cnt, so a final partial group performs exactly the remaining count.
  for (genvar i = 0; i < UNROLL; i++) begin : g_stage
    logic [BITWIDTH-1:0] din;
    logic [BITWIDTH-1:0] dbl;
    logic [BITWIDTH-1:0] dout;

    if (i == 0) begin : g_head
      assign din = x_q;
    end else begin : g_link
      assign din = g_stage[i-1].dout;
    end

    mod_pow2_mul_seq_doubler #(.BITWIDTH(BITWIDTH)) u_dbl (
      .x   (din),
      .mod (mod_q),
      .y   (dbl)
    );

    assign dout = (i < int'(cnt_q)) ? dbl : din;
  end

  assign run_res  = g_stage[UNROLL-1].dout;
  assign cnt_step = (int'(cnt_q) >= UNROLL) ? (cnt_q - SHIFTW'(UNROLL)) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    mod_d   = mod_q;
    odata_d = odata_q;
    err_d   = err_q;

    if (iClr) begin
      // Abort: drop the op, clear the flag, keep the last published result.
      state_d = IDLE;
      err_d   = 1'b0;
    end else if (iEn) begin
      unique case (state_q)
        IDLE: begin
          if (bus.iValid) begin
            if ((bus.iMod < BITWIDTH'(2)) || (bus.iData >= bus.iMod)) begin
              odata_d = bus.iData;
              err_d   = 1'b1;
              state_d = DONE;
            end else if (bus.iShift == '0) begin
              odata_d = bus.iData;
              err_d   = 1'b0;
              state_d = DONE;
            end else begin
              x_d     = bus.iData;
              mod_d   = bus.iMod;
              cnt_d   = bus.iShift;
              err_d   = 1'b0;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          x_d   = run_res;
          cnt_d = cnt_step;
          if (cnt_step == '0) begin
            odata_d = run_res;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.iReady) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      mod_q   <= '0;
      odata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      mod_q   <= mod_d;
      odata_q <= odata_d;
      err_q   <= err_d;
    end
  end

  assign bus.oReady = (state_q == IDLE) && iEn && !iClr;
  assign bus.oValid = (state_q == DONE);
  assign bus.oData  = odata_q;
  assign bus.oErr   = err_q;

endmodule

// File: tb/tb_mod_pow2_mul_seq.sv
// Bench for mod_pow2_mul_seq: UNROLL=1 and UNROLL=4 instances run the same requests side by side.
// Latency figures below count clock edges after the accepting edge (0 = result visible
// in the cycle right after accept, as for k=0 and operand errors).
module tb_mod_pow2_mul_seq;

  logic clk = 1'b0;
  logic rst, en, clr;
  always #5 clk = ~clk;

  mod_pow2_mul_seq_if #(.BITWIDTH(32), .SHIFTW(6)) if1 ();
  mod_pow2_mul_seq_if #(.BITWIDTH(32), .SHIFTW(6)) if4 ();

  mod_pow2_mul_seq #(.BITWIDTH(32), .SHIFTW(6), .UNROLL(1)) dut1 (
    .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr), .bus(if1)
  );
  mod_pow2_mul_seq #(.BITWIDTH(32), .SHIFTW(6), .UNROLL(4)) dut4 (
    .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr), .bus(if4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: d * 2^k mod m computed directly on a wide integer.
  function automatic logic [31:0] ref_mul(input logic [31:0] d, input logic [31:0] m, input int k);
    logic [127:0] p;
    p = {96'd0, d} << k;
    return 32'(p % {96'd0, m});
  endfunction

  function automatic bit ref_err(input logic [31:0] d, input logic [31:0] m);
    return (m < 32'd2) || (d >= m);
  endfunction

  task automatic set_req(input logic [31:0] d, input logic [31:0] m, input logic [5:0] k, input logic v);
    if1.iValid = v; if1.iData = d; if1.iMod = m; if1.iShift = k;
    if4.iValid = v; if4.iData = d; if4.iMod = m; if4.iShift = k;
  endtask

  task automatic set_rdy(input logic r1, input logic r4);
    if1.iReady = r1;
    if4.iReady = r4;
  endtask

  // Drives one request into both instances and collects each result.
  // ok=0 on timeout or if a held result changes before its handshake.
  task automatic do_op(input logic [31:0] d, input logic [31:0] m, input logic [5:0] k,
                       input bit rnd, input logic [63:0] en_mask,
                       output int lat1, output int lat4,
                       output logic [31:0] r1, output logic [31:0] r4,
                       output logic e1, output logic e4, output bit ok);
    bit acc, s1, s4, d1, d4, rd1, rd4, f1, f4;
    int c;
    lat1 = -1; lat4 = -1; r1 = '0; r4 = '0; e1 = 1'b0; e4 = 1'b0; ok = 1'b1;
    acc = 0; s1 = 0; s4 = 0; d1 = 0; d4 = 0; c = 0;
    while (!acc && c < 50) begin
      @(negedge clk);
      en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      set_req(d, m, k, 1'b1);
      set_rdy(1'b0, 1'b0);
      @(posedge clk);
      acc = en;
      c++;
    end
    #1;
    set_req($urandom, $urandom, 6'($urandom_range(0, 63)), 1'b0);
    if (!acc) ok = 1'b0;
    else begin
      if (if1.oValid === 1'b1) begin s1 = 1; lat1 = 0; r1 = if1.oData; e1 = if1.oErr; end
      if (if4.oValid === 1'b1) begin s4 = 1; lat4 = 0; r4 = if4.oData; e4 = if4.oErr; end
      c = 0;
      while (!(d1 && d4) && c < 400) begin
        @(negedge clk);
        en  = rnd ? ($urandom_range(0, 7) != 0) : ((c < 64) ? en_mask[c] : 1'b1);
        rd1 = s1 && !d1 && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        rd4 = s4 && !d4 && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        set_rdy(rd1, rd4);
        f1 = rd1 && en;
        f4 = rd4 && en;
        @(posedge clk);
        #1;
        c++;
        if (f1) begin d1 = 1; if (if1.oValid !== 1'b0) ok = 1'b0; end
        else if (s1 && !d1) begin
          if (if1.oValid !== 1'b1 || if1.oData !== r1 || if1.oErr !== e1) ok = 1'b0;
        end else if (!s1 && if1.oValid === 1'b1) begin
          s1 = 1; lat1 = c; r1 = if1.oData; e1 = if1.oErr;
        end
        if (f4) begin d4 = 1; if (if4.oValid !== 1'b0) ok = 1'b0; end
        else if (s4 && !d4) begin
          if (if4.oValid !== 1'b1 || if4.oData !== r4 || if4.oErr !== e4) ok = 1'b0;
        end else if (!s4 && if4.oValid === 1'b1) begin
          s4 = 1; lat4 = c; r4 = if4.oData; e4 = if4.oErr;
        end
      end
      if (!(d1 && d4)) ok = 1'b0;
    end
    set_rdy(1'b0, 1'b0);
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0;
    set_req('0, '0, '0, 1'b0);
    set_rdy(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (if1.oValid !== 1'b0 || if1.oData !== 32'd0 || if1.oErr !== 1'b0 || if1.oReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_u1: valid=%b data=%h err=%b ready=%b, required 0 00000000 0 1",
               if1.oValid, if1.oData, if1.oErr, if1.oReady);
    end
    n_tests++;
    if (if4.oValid !== 1'b0 || if4.oData !== 32'd0 || if4.oErr !== 1'b0 || if4.oReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_u4: valid=%b data=%h err=%b ready=%b, required 0 00000000 0 1",
               if4.oValid, if4.oData, if4.oErr, if4.oReady);
    end
  endtask

  // Directed operand table, including the carry-bit path near 2^32.
  task automatic test_directed();
    logic [31:0] td [4] = '{32'd5, 32'd9, 32'd22, 32'hFFFF_FFFA};
    logic [31:0] tm [4] = '{32'd23, 32'd23, 32'd23, 32'hFFFF_FFFB};
    logic [5:0]  tk [4] = '{6'd3, 6'd0, 6'd10, 6'd1};
    logic [31:0] tx [4] = '{32'd17, 32'd9, 32'd11, 32'hFFFF_FFF9};
    int          tl1 [4] = '{3, 0, 10, 1};
    int          tl4 [4] = '{1, 0, 3, 1};
    int l1, l4; logic [31:0] r1, r4; logic e1, e4; bit ok;
    for (int i = 0; i < 4; i++) begin
      do_op(td[i], tm[i], tk[i], 1'b0, '1, l1, l4, r1, r4, e1, e4, ok);
      n_tests++;
      if (!ok || r1 !== tx[i] || e1 !== 1'b0 || l1 != tl1[i]) begin
        n_fail++;
        $display("FAIL directed_u1[%0d]: ok=%0b data=%h err=%b lat=%0d, required data=%h err=0 lat=%0d",
                 i, ok, r1, e1, l1, tx[i], tl1[i]);
      end
      n_tests++;
      if (!ok || r4 !== tx[i] || e4 !== 1'b0 || l4 != tl4[i]) begin
        n_fail++;
        $display("FAIL directed_u4[%0d]: ok=%0b data=%h err=%b lat=%0d, required data=%h err=0 lat=%0d",
                 i, ok, r4, e4, l4, tx[i], tl4[i]);
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] td [3] = '{32'd23, 32'd0, 32'd30};
    logic [31:0] tm [3] = '{32'd23, 32'd1, 32'd23};
    logic [5:0]  tk [3] = '{6'd5, 6'd3, 6'd0};
    int l1, l4; logic [31:0] r1, r4; logic e1, e4; bit ok;
    for (int i = 0; i < 3; i++) begin
      do_op(td[i], tm[i], tk[i], 1'b0, '1, l1, l4, r1, r4, e1, e4, ok);
      n_tests++;
      if (!ok || r1 !== td[i] || e1 !== 1'b1 || l1 != 0 || r4 !== td[i] || e4 !== 1'b1 || l4 != 0) begin
        n_fail++;
        $display("FAIL error[%0d]: ok=%0b u1 %h/%b/%0d u4 %h/%b/%0d, required data=%h err=1 lat=0",
                 i, ok, r1, e1, l1, r4, e4, l4, td[i]);
      end
    end
  endtask

  task automatic test_enable();
    int bad; int l1, l4; logic [31:0] r1, r4; logic e1, e4; bit ok;
    // Enable low in IDLE: no ready, nothing accepted.
    bad = 0;
    @(negedge clk);
    en = 1'b0;
    set_req(32'd9, 32'd23, 6'd0, 1'b1);
    repeat (3) begin
      #1;
      if (if1.oReady !== 1'b0 || if4.oReady !== 1'b0) bad++;
      @(posedge clk);
      #1;
      if (if1.oValid !== 1'b0 || if4.oValid !== 1'b0) bad++;
      @(negedge clk);
    end
    set_req('0, '0, '0, 1'b0);
    en = 1'b1;
    @(posedge clk);
    #1;
    if (if1.oValid !== 1'b0 || if4.oValid !== 1'b0) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL enable_idle: %0d violations of ready=0/no accept while disabled, required 0", bad);
    end
    // Enable low for the two cycles right after accept: two extra edges, same result.
    do_op(32'd7, 32'd23, 6'd4, 1'b0, ~64'h3, l1, l4, r1, r4, e1, e4, ok);
    n_tests++;
    if (!ok || r1 !== 32'd20 || l1 != 6 || r4 !== 32'd20 || l4 != 3) begin
      n_fail++;
      $display("FAIL enable_run: ok=%0b u1 %h lat=%0d u4 %h lat=%0d, required 00000014 lat 6 / lat 3",
               ok, r1, l1, r4, l4);
    end
  endtask

  task automatic test_stall();
    bit seen;
    @(negedge clk);
    en = 1'b1;
    set_req(32'd5, 32'd23, 6'd3, 1'b1);
    set_rdy(1'b0, 1'b0);
    @(posedge clk);
    #1;
    set_req('0, '0, '0, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (if1.oValid === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL stall_wait: oValid still low after 20 cycles, required high after 3");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (if1.oValid !== 1'b1 || if1.oData !== 32'd17 || if1.oReady !== 1'b0 ||
          if4.oValid !== 1'b1 || if4.oData !== 32'd17) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: u1 v=%b d=%h rdy=%b u4 v=%b d=%h, required v=1 d=00000011 rdy=0",
                 i, if1.oValid, if1.oData, if1.oReady, if4.oValid, if4.oData);
      end
    end
    @(negedge clk);
    set_rdy(1'b1, 1'b1);
    @(posedge clk);
    #1;
    set_rdy(1'b0, 1'b0);
    n_tests++;
    if (if1.oValid !== 1'b0 || if1.oReady !== 1'b1 || if4.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: u1 v=%b rdy=%b u4 v=%b, required 0 1 0",
               if1.oValid, if1.oReady, if4.oValid);
    end
  endtask

  task automatic test_clear();
    int bad;
    @(negedge clk);
    set_req(32'd9, 32'd23, 6'd40, 1'b1);
    @(posedge clk);
    #1;
    set_req('0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    n_tests++;
    if (if1.oReady !== 1'b0 || if4.oReady !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: u1=%b u4=%b while clearing, required 0", if1.oReady, if4.oReady);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_tests++;
    if (if1.oReady !== 1'b1 || if4.oReady !== 1'b1 || if1.oValid !== 1'b0 || if4.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: ready %b/%b valid %b/%b, required ready 1 valid 0",
               if1.oReady, if4.oReady, if1.oValid, if4.oValid);
    end
    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (if1.oValid !== 1'b0 || if4.oValid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || if1.oData !== 32'd17 || if4.oData !== 32'd17) begin
      n_fail++;
      $display("FAIL clear_discard: valid seen %0d times, data %h/%h, required 0 times and 00000011",
               bad, if1.oData, if4.oData);
    end
    // Reset in the middle of an operation.
    @(negedge clk);
    set_req(32'd5, 32'd23, 6'd30, 1'b1);
    @(posedge clk);
    #1;
    set_req('0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (if1.oData !== 32'd0 || if1.oValid !== 1'b0 || if1.oErr !== 1'b0 ||
        if4.oData !== 32'd0 || if4.oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: u1 d=%h v=%b e=%b u4 d=%h v=%b, required all zero",
               if1.oData, if1.oValid, if1.oErr, if4.oData, if4.oValid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (if1.oReady !== 1'b1 || if4.oReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: %b/%b, required 1", if1.oReady, if4.oReady);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, m, xd; logic [5:0] k; logic xe;
    int l1, l4; logic [31:0] r1, r4; logic e1, e4; bit ok;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) m = 32'd23;
      else m = $urandom | 32'd1;
      if (m < 32'd3) m = 32'd3;
      d = $urandom % m;
      if ($urandom_range(0, 15) == 0) d = m;
      if ($urandom_range(0, 31) == 0) m = 32'($urandom_range(0, 1));
      k  = 6'($urandom_range(0, 63));
      xe = ref_err(d, m);
      xd = xe ? d : ref_mul(d, m, int'(k));
      do_op(d, m, k, 1'b1, '1, l1, l4, r1, r4, e1, e4, ok);
      n_tests++;
      if (!ok || r1 !== xd || e1 !== xe) begin
        n_fail++;
        $display("FAIL random_u1[%0d]: d=%h m=%h k=%0d ok=%0b got %h err=%b, required %h err=%b",
                 i, d, m, k, ok, r1, e1, xd, xe);
      end
      n_tests++;
      if (!ok || r4 !== xd || e4 !== xe) begin
        n_fail++;
        $display("FAIL random_u4[%0d]: d=%h m=%h k=%0d ok=%0b got %h err=%b, required %h err=%b",
                 i, d, m, k, ok, r4, e4, xd, xe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_error();
    test_enable();
    test_stall();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
